// File: rtl/ysyx_23060201_lsu_if.sv
// Request, response and memory-port bundle of the load/store unit.
// master = environment (EXU/WBU/memory side), slave = the LSU itself.
interface ysyx_23060201_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_ren;
    logic                  in_wen;
    logic [2:0]            in_funct3;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_rdata;
    logic                  out_err;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_ack;

    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata,
        output out_ready, mem_rdata, mem_ack,
        input  in_ready, out_valid, out_rdata, out_err,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );

    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata,
        input  out_ready, mem_rdata, mem_ack,
        output in_ready, out_valid, out_rdata, out_err,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Single-request load/store unit: IDLE -> MEM -> RESP, with lane shifting for
// stores and sign/zero extension for loads. All outputs are registered.
module ysyx_23060201_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_23060201_lsu_if.slave  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] f_load_ext(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b010:  return sh;
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: return '0;
        endcase
    endfunction

    function automatic logic [7:0] f_store_mask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3[1:0])
            2'b00:   return 8'h01 << off;
            2'b01:   return 8'h03 << off;
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_store_data(
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            off
    );
        return wdata << {off, 3'b000};
    endfunction

    // Request decode, evaluated only while IDLE.
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_both;
    logic                  w_f3_ok_ld;
    logic                  w_f3_ok_st;
    logic                  w_misalign;
    logic                  w_err;
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_aligned;

    assign w_off      = io_bus.in_addr[1:0];
    assign w_aligned  = {io_bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_is_load  = io_bus.in_ren & ~io_bus.in_wen;
    assign w_is_store = io_bus.in_wen & ~io_bus.in_ren;
    assign w_both     = io_bus.in_ren & io_bus.in_wen;
    assign w_f3_ok_ld = io_bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign w_f3_ok_st = io_bus.in_funct3 inside {3'b000, 3'b001, 3'b010};
    assign w_misalign = ((io_bus.in_funct3[1:0] == 2'b01) & w_off[0]) |
                        ((io_bus.in_funct3[1:0] == 2'b10) & (w_off != 2'b00));
    assign w_err      = w_both |
                        (w_is_load  & (~w_f3_ok_ld | w_misalign)) |
                        (w_is_store & (~w_f3_ok_st | w_misalign));

    state_t                r_state;
    logic                  r_ren;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_out_err;
    logic [DATA_WIDTH-1:0] r_out_rdata;
    logic                  r_mem_ren;
    logic                  r_mem_wen;
    logic [ADDR_WIDTH-1:0] r_mem_raddr;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [7:0]            r_mem_wmask;

    // Async reset drops the memory strobes immediately, abandoning any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ren       <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_rdata <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_ren      <= w_is_load;
                        r_funct3   <= io_bus.in_funct3;
                        r_off      <= w_off;
                        if (w_err || (!w_is_load && !w_is_store)) begin
                            r_state     <= S_RESP;
                            r_out_valid <= 1'b1;
                            r_out_err   <= w_err;
                            r_out_rdata <= '0;
                        end else begin
                            r_state     <= S_MEM;
                            r_mem_ren   <= w_is_load;
                            r_mem_wen   <= w_is_store;
                            r_mem_raddr <= w_aligned;
                            r_mem_waddr <= w_aligned;
                            r_mem_wdata <= w_is_store ? f_store_data(io_bus.in_wdata, w_off) : '0;
                            r_mem_wmask <= w_is_store ? f_store_mask(io_bus.in_funct3, w_off) : 8'h00;
                        end
                    end
                end
                S_MEM: begin
                    if (io_bus.mem_ack) begin
                        r_state     <= S_RESP;
                        r_mem_ren   <= 1'b0;
                        r_mem_wen   <= 1'b0;
                        r_mem_raddr <= '0;
                        r_mem_waddr <= '0;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= 8'h00;
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b0;
                        r_out_rdata <= r_ren ? f_load_ext(io_bus.mem_rdata, r_off, r_funct3) : '0;
                    end
                end
                S_RESP: begin
                    if (io_bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_out_rdata <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_err   <= 1'b0;
                    r_mem_ren   <= 1'b0;
                    r_mem_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_err   = r_out_err;
    assign io_bus.out_rdata = r_out_rdata;
    assign io_bus.mem_ren   = r_mem_ren;
    assign io_bus.mem_wen   = r_mem_wen;
    assign io_bus.mem_raddr = r_mem_raddr;
    assign io_bus.mem_waddr = r_mem_waddr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for ysyx_23060201_lsu: a per-request behavioural model plus a
// per-cycle compare process, and literal expectations for the key scenarios.
module tb_ysyx_23060201_lsu;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ysyx_23060201_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected behaviour of the request currently in flight
    logic        exp_err, exp_ren, exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_wmask;

    // Observations of the last request
    logic [31:0] s_raddr, s_waddr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;
    logic        s_err;
    int          g_lat, g_nv, g_ns;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic void model(input logic ren, input logic wen, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
        int     off, size;
        bit     e;
        longint v;
        off  = int'(addr % 4);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (ren && wen)  e = 1;
        else if (ren)    e = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (off % size != 0);
        else if (wen)    e = !(f3 inside {3'd0, 3'd1, 3'd2}) || (off % size != 0);
        else             e = 0;
        exp_err   = e;
        exp_ren   = !e && ren;
        exp_wen   = !e && wen;
        exp_addr  = addr - 32'(off);
        exp_wmask = exp_wen ? 8'(((1 << size) - 1) << off) : 8'h00;
        exp_wdata = exp_wen ? 32'(wdata << (8 * off)) : 32'h0;
        exp_rdata = 32'h0;
        if (exp_ren) begin
            v = longint'(rdata) >> (8 * off);
            v = v & ((longint'(1) << (8 * size)) - 1);
            if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 1) == 1))
                v = v - (longint'(1) << (8 * size));
            exp_rdata = 32'(v);
        end
    endfunction

    // Per-cycle check of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_inv", bus.in_ready, !(bus.mem_ren || bus.mem_wen || bus.out_valid));
            if (bus.mem_ren || bus.mem_wen) begin
                chk("mem_strobes", {bus.mem_ren, bus.mem_wen}, {exp_ren, exp_wen});
                chk("mem_raddr", bus.mem_raddr, exp_addr);
                chk("mem_waddr", bus.mem_waddr, exp_addr);
                chk("mem_wdata", bus.mem_wdata, exp_wdata);
                chk("mem_wmask", bus.mem_wmask, exp_wmask);
            end else begin
                chk("mem_idle_bus", {bus.mem_raddr, bus.mem_waddr}, 64'h0);
                chk("mem_idle_dm", {bus.mem_wdata, bus.mem_wmask}, 64'h0);
            end
            if (bus.out_valid) begin
                chk("out_rdata", bus.out_rdata, exp_rdata);
                chk("out_err", bus.out_err, exp_err);
            end
        end
    end

    task automatic run_req(input logic ren, input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_dly, input int rdy_dly);
        int k;
        bit done;
        model(ren, wen, f3, addr, wdata, rdata);
        s_raddr = 0; s_waddr = 0; s_wdata = 0; s_wmask = 0; s_rdata = 0; s_err = 0;
        g_lat = 0; g_nv = 0; g_ns = 0;
        @(posedge clk); #1;
        chk("idle_in_ready", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_ren    = ren;
        bus.in_wen    = wen;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 1;
        done = 0;
        while (!done && k <= 40) begin
            bus.mem_ack = (k > ack_dly);
            @(negedge clk);
            if (bus.mem_ren || bus.mem_wen) begin
                g_ns++;
                s_raddr = bus.mem_raddr; s_waddr = bus.mem_waddr;
                s_wdata = bus.mem_wdata; s_wmask = bus.mem_wmask;
            end
            if (bus.out_valid) begin
                if (g_nv == 0) begin
                    g_lat = k; s_rdata = bus.out_rdata; s_err = bus.out_err;
                end
                g_nv++;
                bus.out_ready = (g_nv > rdy_dly);
                done = bus.out_ready;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b0;
        bus.mem_ack   = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: no completed response after %0d cycles, want one", k);
        end
        chk("latency", g_lat, (exp_ren || exp_wen) ? 2 + ack_dly : 1);
        chk("valid_cycles", g_nv, rdy_dly + 1);
        chk("strobe_cycles", g_ns, (exp_ren || exp_wen) ? ack_dly + 1 : 0);
        @(negedge clk);
        chk("post_out_valid", bus.out_valid, 1'b0);
        chk("post_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ren    = 1'b0;
        bus.in_wen    = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_addr   = 32'h0;
        bus.in_wdata  = 32'h0;
        bus.out_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
        exp_err = 0; exp_ren = 0; exp_wen = 0;
        exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_wmask = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_ctrl", {bus.out_valid, bus.out_err, bus.mem_ren, bus.mem_wen}, 4'b0000);
        chk("rst_rdata", bus.out_rdata, 32'h0);
        chk("rst_bus", {bus.mem_raddr, bus.mem_waddr}, 64'h0);
        chk("rst_wdm", {bus.mem_wdata, bus.mem_wmask}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SB at byte 3
        run_req(1'b0, 1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0, 0, 0);
        chk("sb_waddr", s_waddr, 32'h80000000);
        chk("sb_wmask", s_wmask, 8'h08);
        chk("sb_wdata", s_wdata, 32'hA5000000);
        chk("sb_lat", g_lat, 2);
        chk("sb_resp", {s_err, s_rdata}, 33'h0);

        // LB / LHU at byte 2
        run_req(1'b1, 1'b0, 3'b000, 32'h80000002, 32'h0, 32'h12F34567, 0, 0);
        chk("lb_rdata", s_rdata, 32'hFFFFFFF3);
        chk("lb_raddr", s_raddr, 32'h80000000);
        run_req(1'b1, 1'b0, 3'b101, 32'h80000002, 32'h0, 32'h12F34567, 0, 0);
        chk("lhu_rdata", s_rdata, 32'h000012F3);
        chk("lhu_raddr", s_raddr, 32'h80000000);

        // Misaligned LW
        run_req(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0, 32'hFFFFFFFF, 0, 0);
        chk("mis_lw_err", s_err, 1'b1);
        chk("mis_lw_rdata", s_rdata, 32'h0);
        chk("mis_lw_strobes", g_ns, 0);

        // Slow memory plus back-pressure on a SW
        run_req(1'b0, 1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF, 32'h0, 3, 2);
        chk("sw_strobe_cycles", g_ns, 4);
        chk("sw_valid_cycles", g_nv, 3);
        chk("sw_wmask", s_wmask, 8'h0F);
        chk("sw_wdata", s_wdata, 32'hDEADBEEF);

        // Reset in the middle of an LW
        model(1'b1, 1'b0, 3'b010, 32'h80000040, 32'h0, 32'h11111111);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_ren = 1'b1; bus.in_wen = 1'b0;
        bus.in_funct3 = 3'b010; bus.in_addr = 32'h80000040; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_ren_before", bus.mem_ren, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ren_async", bus.mem_ren, 1'b0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", {bus.out_valid, bus.mem_ren}, 2'b00);
        end
        bus.mem_ack = 1'b0;
        run_req(1'b1, 1'b0, 3'b010, 32'h80000020, 32'h0, 32'hCAFEF00D, 1, 0);
        chk("lw_after_rst", s_rdata, 32'hCAFEF00D);

        // No-op and both-strobe requests
        run_req(1'b0, 1'b0, 3'b010, 32'h80000000, 32'h0, 32'h0, 0, 0);
        chk("noop_err", s_err, 1'b0);
        chk("noop_strobes", g_ns, 0);
        run_req(1'b1, 1'b1, 3'b010, 32'h80000000, 32'h12345678, 32'h0, 0, 0);
        chk("both_err", s_err, 1'b1);
        chk("both_strobes", g_ns, 0);

        // Further lanes, signs and error codes
        run_req(1'b0, 1'b1, 3'b001, 32'h80000102, 32'h0000BEEF, 32'h0, 1, 1);
        chk("sh_wmask", s_wmask, 8'h0C);
        chk("sh_wdata", s_wdata, 32'hBEEF0000);
        run_req(1'b1, 1'b0, 3'b001, 32'h80000202, 32'h0, 32'h8001ABCD, 0, 0);
        chk("lh_rdata", s_rdata, 32'hFFFF8001);
        run_req(1'b1, 1'b0, 3'b100, 32'h80000301, 32'h0, 32'h1234C5AA, 2, 0);
        chk("lbu_rdata", s_rdata, 32'h000000C5);
        run_req(1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0, 32'h0, 0, 0);
        chk("rsvd_ld_err", s_err, 1'b1);
        run_req(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h0000FFFF, 32'h0, 0, 0);
        chk("mis_sh_err", s_err, 1'b1);
        run_req(1'b0, 1'b1, 3'b100, 32'h80000000, 32'h0, 32'h0, 0, 0);
        chk("rsvd_st_err", s_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
